// File: rtl/sm_out_fifo.sv
// sm_out_fifo: FWFT buffer for a push-only result stream; SM_OUT_FIFO_STICKY_OVF_EN makes ovf sticky.
module sm_out_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_dval,
  input  logic [DW-1:0] i,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o,
  output logic [CW-1:0] o_cnt,
  output logic          ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push, pop, drop;
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = ~empty & o_ready;
  assign push  = i_dval & (~full | pop);
  assign drop  = i_dval & full & ~pop;
  always_comb begin
    wp_d  = push ? wp_q + PW'(1) : wp_q;
    rp_d  = pop ? rp_q + PW'(1) : rp_q;
    cnt_d = CW'(wp_d - rp_d);
`ifdef SM_OUT_FIFO_STICKY_OVF_EN
    ovf_d = ovf_q | drop;
`else
    ovf_d = drop;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= i;
  end
  assign o_valid = ~empty;
  assign o       = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign o_cnt   = cnt_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_sm_out_fifo.sv
// tb_sm_out_fifo: directed vectors plus wrap, async-reset and overflow-mode sequences.
module tb_sm_out_fifo;
`ifdef SM_OUT_FIFO_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv = 1'b0;
  logic [9:0] din = '0;
  logic       rdy = 1'b0;
  logic       valid;
  logic [9:0] dout;
  logic [2:0] cnt;
  logic       ovf;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sm_out_fifo dut (
    .clk(clk), .rst(rst), .i_dval(dv), .i(din), .o_valid(valid),
    .o_ready(rdy), .o(dout), .o_cnt(cnt), .ovf(ovf)
  );
  typedef struct {
    logic rst; logic dv; logic [9:0] d; logic rdy;
    logic v; logic [9:0] o; logic [2:0] cnt; logic ovp; logic ovs;
  } vec_t;
  vec_t tbl[27];
  function automatic vec_t mv(logic r, logic d, logic [9:0] x, logic y,
                              logic v, logic [9:0] o, logic [2:0] c, logic p, logic s);
    vec_t t;
    t = '{r, d, x, y, v, o, c, p, s};
    return t;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  int q[$];
  int sent, rcv;
  initial begin
    tbl[0]  = mv(0, 0, 0,      0, 0, 0,      0, 0, 0);
    tbl[1]  = mv(1, 1, 'h123,  1, 1, 'h123,  1, 0, 0);
    tbl[2]  = mv(1, 0, 0,      1, 0, 0,      0, 0, 0);
    tbl[3]  = mv(1, 1, 5,      0, 1, 5,      1, 0, 0);
    tbl[4]  = mv(1, 1, 6,      0, 1, 5,      2, 0, 0);
    tbl[5]  = mv(1, 1, 7,      0, 1, 5,      3, 0, 0);
    tbl[6]  = mv(1, 1, 8,      0, 1, 5,      4, 0, 0);
    tbl[7]  = mv(1, 1, 9,      0, 1, 5,      4, 1, 1);
    tbl[8]  = mv(1, 0, 0,      0, 1, 5,      4, 0, 1);
    tbl[9]  = mv(1, 0, 0,      1, 1, 6,      3, 0, 1);
    tbl[10] = mv(1, 0, 0,      1, 1, 7,      2, 0, 1);
    tbl[11] = mv(1, 0, 0,      1, 1, 8,      1, 0, 1);
    tbl[12] = mv(1, 0, 0,      1, 0, 0,      0, 0, 1);
    tbl[13] = mv(0, 0, 0,      0, 0, 0,      0, 0, 0);
    tbl[14] = mv(1, 1, 1,      0, 1, 1,      1, 0, 0);
    tbl[15] = mv(1, 1, 2,      0, 1, 1,      2, 0, 0);
    tbl[16] = mv(1, 1, 3,      0, 1, 1,      3, 0, 0);
    tbl[17] = mv(1, 1, 4,      0, 1, 1,      4, 0, 0);
    tbl[18] = mv(1, 1, 10,     1, 1, 2,      4, 0, 0);
    tbl[19] = mv(1, 0, 0,      1, 1, 3,      3, 0, 0);
    tbl[20] = mv(1, 0, 0,      1, 1, 4,      2, 0, 0);
    tbl[21] = mv(1, 0, 0,      1, 1, 10,     1, 0, 0);
    tbl[22] = mv(1, 0, 0,      1, 0, 0,      0, 0, 0);
    tbl[23] = mv(1, 0, 0,      1, 0, 0,      0, 0, 0);
    tbl[24] = mv(1, 1, 'h55,   1, 1, 'h55,   1, 0, 0);
    tbl[25] = mv(1, 1, 'h66,   1, 1, 'h66,   1, 0, 0);
    tbl[26] = mv(1, 0, 0,      1, 0, 0,      0, 0, 0);
    #2;
    for (int k = 0; k < 27; k++) begin
      rst = tbl[k].rst; dv = tbl[k].dv; din = tbl[k].d; rdy = tbl[k].rdy;
      tick();
      chk($sformatf("r%0d_valid", k), int'(valid), int'(tbl[k].v));
      chk($sformatf("r%0d_cnt", k), int'(cnt), int'(tbl[k].cnt));
      chk($sformatf("r%0d_ovf", k), int'(ovf), int'(STICKY ? tbl[k].ovs : tbl[k].ovp));
      if (tbl[k].v) chk($sformatf("r%0d_o", k), int'(dout), int'(tbl[k].o));
    end
    // wrap stress: 3*DEPTH+1 words, random ready, input gated to avoid drops
    sent = 0; rcv = 0;
    for (int c = 0; c < 200 && (sent < 13 || q.size() > 0); c++) begin
      rdy = 1'($urandom_range(0, 1));
      dv = (sent < 13) && (cnt < 3'd4 || rdy);
      din = 10'('h100 + sent);
      #1;
      if (valid && rdy) begin
        chk($sformatf("wrap_o%0d", rcv), int'(dout), q.size() > 0 ? q[0] : -1);
        if (q.size() > 0) void'(q.pop_front());
        rcv++;
      end
      if (dv) begin
        q.push_back(int'(din));
        sent++;
      end
      tick();
      if (ovf) chk("wrap_ovf", int'(ovf), 0);
    end
    dv = 1'b0; rdy = 1'b0;
    chk("wrap_count", rcv, 13);
    chk("wrap_empty", int'(valid), 0);
    // asynchronous reset with three words buffered
    for (int k = 0; k < 3; k++) begin
      dv = 1'b1; din = 10'(k + 20);
      tick();
    end
    dv = 1'b0;
    chk("pre_rst_cnt", int'(cnt), 3);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_ovf", int'(ovf), 0);
    chk("async_rst_o", int'(dout), 0);
    tick();
    rst = 1'b1; dv = 1'b1; din = 10'h3ff;
    tick();
    dv = 1'b0;
    chk("post_rst_valid", int'(valid), 1);
    chk("post_rst_o", int'(dout), 'h3ff);
    chk("post_rst_cnt", int'(cnt), 1);
    // overflow mode: fill, then two drops five cycles apart
    for (int k = 0; k < 3; k++) begin
      dv = 1'b1; din = 10'(k + 40);
      tick();
    end
    chk("ovm_full", int'(cnt), 4);
    for (int k = 0; k < 8; k++) begin
      dv = (k == 0 || k == 5);
      din = 10'h2aa;
      tick();
      chk($sformatf("ovm_ovf%0d", k), int'(ovf), int'(STICKY ? 1'b1 : (k == 0 || k == 5)));
    end
    dv = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovm_o%0d", k), int'(dout), k == 0 ? 'h3ff : 40 + k - 1);
      tick();
    end
    chk("ovm_drained", int'(valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
